// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg
// Shared constants for the ALU execute stage:
//   - 4-bit ALU control codes driven on alu_ctl and consumed by alu_exec_core
//   - main-control alu_op class encodings
//   - the four R-type opcode fields (instruction[31:21]) this stage decodes
package alu_exec_pkg;

  // ALU control codes
  localparam logic [3:0] CTL_AND     = 4'b0000;
  localparam logic [3:0] CTL_OR      = 4'b0001;
  localparam logic [3:0] CTL_ADD     = 4'b0010;
  localparam logic [3:0] CTL_SUB     = 4'b0110;
  localparam logic [3:0] CTL_PASSB   = 4'b0111;
  localparam logic [3:0] CTL_NOR     = 4'b1100;
  localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

  // Main-control ALU class
  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_CBR   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  // R-type opcode fields
  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

endpackage

// File: rtl/alu_exec_core.sv
// alu_exec_core
// Purely combinational ALU datapath. Add/subtract wrap modulo 2^WIDTH.
// Ports:
//   a, b      : operands
//   ctl       : 4-bit ALU control code (see alu_exec_pkg)
//   result    : ALU result (0 for any unused/illegal code)
//   zero      : high when result is 0
// Optional (macro ALU_FLAGS_EN): carry, overflow (signed, add/sub only),
//   negative (result MSB).
module alu_exec_core
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctl,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow,
  output logic             negative
`endif
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

`ifdef ALU_FLAGS_EN
  // Subtraction is done as a + ~b + 1 so the top bit is the ARM-style
  // carry (set when no borrow occurred).
  logic [WIDTH:0] sumExt;
  logic [WIDTH:0] diffExt;
  assign sumExt  = {1'b0, a} + {1'b0, b};
  assign diffExt = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign sum     = sumExt[WIDTH-1:0];
  assign diff    = diffExt[WIDTH-1:0];
`else
  assign sum  = a + b;
  assign diff = a - b;
`endif

  always_comb begin
    result = '0;
    case (ctl)
      CTL_AND:   result = a & b;
      CTL_OR:    result = a | b;
      CTL_ADD:   result = sum;
      CTL_SUB:   result = diff;
      CTL_PASSB: result = b;
      CTL_NOR:   result = ~(a | b);
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_FLAGS_EN
  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    if (ctl == CTL_ADD) begin
      carry    = sumExt[WIDTH];
      overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (ctl == CTL_SUB) begin
      carry    = diffExt[WIDTH];
      overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
  end

  assign negative = result[WIDTH-1];
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execute stage: decodes alu_op/opcode into an ALU control code, runs the
// ALU, computes pc+4 / branch target / next pc and registers everything.
// Outputs appear one clk edge after in_valid=1 is sampled; with in_valid=0
// out_valid drops and all other outputs hold.
// Ports:
//   clk, reset (async, active-high)
//   in_valid, alu_op[1:0], opcode[10:0], operand_a, operand_b, pc,
//   branch_offset, branch                                   : inputs
//   out_valid, result, zero, pc_plus4, branch_target, pc_next,
//   alu_ctl[3:0], illegal                                    : registered outputs
// Optional macro ALU_FLAGS_EN adds registered carry, overflow, negative.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [10:0]      opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             branch,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc_next,
  output logic [3:0]       alu_ctl,
  output logic             illegal
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow,
  output logic             negative
`endif
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [3:0]       aluCtlD;
  logic             illegalD;
  logic [WIDTH-1:0] resultD;
  logic             zeroD;
  logic [WIDTH-1:0] pcPlus4D;
  logic [WIDTH-1:0] branchTargetD;
  logic [WIDTH-1:0] pcNextD;

  logic             outValidQ;
  logic [WIDTH-1:0] resultQ;
  logic             zeroQ;
  logic [WIDTH-1:0] pcPlus4Q;
  logic [WIDTH-1:0] branchTargetQ;
  logic [WIDTH-1:0] pcNextQ;
  logic [3:0]       aluCtlQ;
  logic             illegalQ;

  // ALU control decode; anything not listed is illegal and forces the
  // all-ones code, which the ALU maps to a zero result.
  always_comb begin
    aluCtlD  = CTL_ILLEGAL;
    illegalD = 1'b0;
    case (alu_op_e'(alu_op))
      ALUOP_LDST: aluCtlD = CTL_ADD;
      ALUOP_CBR:  aluCtlD = CTL_PASSB;
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_ADD: aluCtlD = CTL_ADD;
          OPC_SUB: aluCtlD = CTL_SUB;
          OPC_AND: aluCtlD = CTL_AND;
          OPC_ORR: aluCtlD = CTL_OR;
          default: illegalD = 1'b1;
        endcase
      end
      default: illegalD = 1'b1;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic carryD, overflowD, negativeD;
  logic carryQ, overflowQ, negativeQ;
`endif

  alu_exec_core #(
    .WIDTH (WIDTH)
  ) uCore (
    .a      (operand_a),
    .b      (operand_b),
    .ctl    (aluCtlD),
    .result (resultD),
    .zero   (zeroD)
`ifdef ALU_FLAGS_EN
    ,
    .carry    (carryD),
    .overflow (overflowD),
    .negative (negativeD)
`endif
  );

  // Branch decision uses this cycle's zero, not the registered one.
  assign pcPlus4D      = pc + PC_STEP;
  assign branchTargetD = pc + branch_offset;
  assign pcNextD       = (branch && zeroD) ? branchTargetD : pcPlus4D;

  // Output registers: capture on in_valid, otherwise only drop out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValidQ     <= 1'b0;
      resultQ       <= '0;
      zeroQ         <= 1'b1;
      pcPlus4Q      <= '0;
      branchTargetQ <= '0;
      pcNextQ       <= '0;
      aluCtlQ       <= 4'b0000;
      illegalQ      <= 1'b0;
    end else begin
      outValidQ <= in_valid;
      if (in_valid) begin
        resultQ       <= resultD;
        zeroQ         <= zeroD;
        pcPlus4Q      <= pcPlus4D;
        branchTargetQ <= branchTargetD;
        pcNextQ       <= pcNextD;
        aluCtlQ       <= aluCtlD;
        illegalQ      <= illegalD;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  // Flag registers follow the same capture rule as the main outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carryQ    <= 1'b0;
      overflowQ <= 1'b0;
      negativeQ <= 1'b0;
    end else if (in_valid) begin
      carryQ    <= carryD;
      overflowQ <= overflowD;
      negativeQ <= negativeD;
    end
  end

  assign carry    = carryQ;
  assign overflow = overflowQ;
  assign negative = negativeQ;
`endif

  assign out_valid     = outValidQ;
  assign result        = resultQ;
  assign zero          = zeroQ;
  assign pc_plus4      = pcPlus4Q;
  assign branch_target = branchTargetQ;
  assign pc_next       = pcNextQ;
  assign alu_ctl       = aluCtlQ;
  assign illegal       = illegalQ;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Directed testbench for alu_exec_unit with hand-computed expected values.
// Honours ALU_FLAGS_EN for the optional flag ports.
module tb_alu_exec_unit;

  localparam int WIDTH = 64;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [1:0]       alu_op;
  logic [10:0]      opcode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] branch_offset;
  logic             branch;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] pc_next;
  logic [3:0]       alu_ctl;
  logic             illegal;
`ifdef ALU_FLAGS_EN
  logic             carry;
  logic             overflow;
  logic             negative;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  alu_exec_unit #(
    .WIDTH (WIDTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .alu_op        (alu_op),
    .opcode        (opcode),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .pc            (pc),
    .branch_offset (branch_offset),
    .branch        (branch),
    .out_valid     (out_valid),
    .result        (result),
    .zero          (zero),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .pc_next       (pc_next),
    .alu_ctl       (alu_ctl),
    .illegal       (illegal)
`ifdef ALU_FLAGS_EN
    ,
    .carry    (carry),
    .overflow (overflow),
    .negative (negative)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expectation and count it
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one input set on the falling edge, let the rising edge capture
  // it and return 1 ns later so outputs can be sampled safely
  task automatic applyStimulus(input logic v, input logic [1:0] op,
                               input logic [10:0] opc,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] pcIn, input logic [63:0] off,
                               input logic br);
    @(negedge clk);
    in_valid      = v;
    alu_op        = op;
    opcode        = opc;
    operand_a     = a;
    operand_b     = b;
    pc            = pcIn;
    branch_offset = off;
    branch        = br;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    alu_op        = 2'b00;
    opcode        = 11'd0;
    operand_a     = '0;
    operand_b     = '0;
    pc            = '0;
    branch_offset = '0;
    branch        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid",  64'(out_valid), 64'd0);
    checkOutput("rst_result", result,         64'd0);
    checkOutput("rst_zero",   64'(zero),      64'd1);
    checkOutput("rst_pcnext", pc_next,        64'd0);
    checkOutput("rst_ctl",    64'(alu_ctl),   64'd0);
    checkOutput("rst_illegal",64'(illegal),   64'd0);
    @(negedge clk);
    reset = 1'b0;

    // R-type ADD 5 + 7
    applyStimulus(1'b1, 2'b10, 11'b10001011000, 64'd5, 64'd7, 64'h200, 64'h0, 1'b0);
    checkOutput("add_valid",  64'(out_valid), 64'd1);
    checkOutput("add_result", result,         64'd12);
    checkOutput("add_zero",   64'(zero),      64'd0);
    checkOutput("add_ctl",    64'(alu_ctl),   64'h2);
    checkOutput("add_illegal",64'(illegal),   64'd0);
    checkOutput("add_plus4",  pc_plus4,       64'h204);

    // R-type SUB of equal operands, back-to-back
    applyStimulus(1'b1, 2'b10, 11'b11001011000, 64'h1234, 64'h1234, 64'h0, 64'h0, 1'b0);
    checkOutput("sub_eq_result", result,       64'd0);
    checkOutput("sub_eq_zero",   64'(zero),    64'd1);
    checkOutput("sub_eq_ctl",    64'(alu_ctl), 64'h6);

    // SUB wrapping below zero: 3 - 5
    applyStimulus(1'b1, 2'b10, 11'b11001011000, 64'd3, 64'd5, 64'h0, 64'h0, 1'b0);
    checkOutput("sub_wrap", result, 64'hFFFF_FFFF_FFFF_FFFE);

    // AND and ORR
    applyStimulus(1'b1, 2'b10, 11'b10001010000, 64'hF0F0, 64'h0FF0, 64'h0, 64'h0, 1'b0);
    checkOutput("and_result", result,       64'h00F0);
    checkOutput("and_ctl",    64'(alu_ctl), 64'h0);
    applyStimulus(1'b1, 2'b10, 11'b10101010000, 64'hF000, 64'h000F, 64'h0, 64'h0, 1'b0);
    checkOutput("orr_result", result,       64'hF00F);
    checkOutput("orr_ctl",    64'(alu_ctl), 64'h1);

    // Load/store address add ignores the opcode field
    applyStimulus(1'b1, 2'b00, 11'b11111111111, 64'h1000, 64'h8, 64'h0, 64'h0, 1'b0);
    checkOutput("ldst_result", result,       64'h1008);
    checkOutput("ldst_ctl",    64'(alu_ctl), 64'h2);

    // Taken branch: B = 0
    applyStimulus(1'b1, 2'b01, 11'd0, 64'h55, 64'h0, 64'h100, 64'h20, 1'b1);
    checkOutput("br_taken_pcnext", pc_next,       64'h120);
    checkOutput("br_taken_plus4",  pc_plus4,      64'h104);
    checkOutput("br_taken_target", branch_target, 64'h120);
    checkOutput("br_taken_ctl",    64'(alu_ctl),  64'h7);
    checkOutput("br_taken_zero",   64'(zero),     64'd1);

    // Not-taken branch: B = 1
    applyStimulus(1'b1, 2'b01, 11'd0, 64'h55, 64'h1, 64'h100, 64'h20, 1'b1);
    checkOutput("br_nt_pcnext", pc_next,  64'h104);
    checkOutput("br_nt_result", result,   64'h1);

    // Zero result but not a branch instruction
    applyStimulus(1'b1, 2'b01, 11'd0, 64'h0, 64'h0, 64'h100, 64'h20, 1'b0);
    checkOutput("nobr_pcnext", pc_next, 64'h104);

    // PC and ALU wrap at all-ones
    applyStimulus(1'b1, 2'b10, 11'b10001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                  64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b0);
    checkOutput("wrap_plus4",  pc_plus4,      64'h0);
    checkOutput("wrap_target", branch_target, 64'h4);
    checkOutput("wrap_result", result,        64'h0);
    checkOutput("wrap_zero",   64'(zero),     64'd1);

    // Illegal R-type opcode
    applyStimulus(1'b1, 2'b10, 11'b00000000000, 64'd9, 64'd9, 64'h40, 64'h0, 1'b0);
    checkOutput("ill_rtype",        64'(illegal), 64'd1);
    checkOutput("ill_rtype_ctl",    64'(alu_ctl), 64'hF);
    checkOutput("ill_rtype_result", result,       64'd0);

    // Reserved alu_op
    applyStimulus(1'b1, 2'b11, 11'b10001011000, 64'd9, 64'd9, 64'h40, 64'h0, 1'b0);
    checkOutput("ill_rsvd",     64'(illegal), 64'd1);
    checkOutput("ill_rsvd_ctl", 64'(alu_ctl), 64'hF);

    // Known value, then an idle cycle must hold it
    applyStimulus(1'b1, 2'b10, 11'b10001011000, 64'd100, 64'd23, 64'h300, 64'h0, 1'b0);
    checkOutput("pre_hold_result", result, 64'd123);
    applyStimulus(1'b0, 2'b10, 11'b11001011000, 64'd1, 64'd1, 64'h0, 64'h0, 1'b1);
    checkOutput("hold_valid",  64'(out_valid), 64'd0);
    checkOutput("hold_result", result,         64'd123);
    checkOutput("hold_zero",   64'(zero),      64'd0);
    checkOutput("hold_plus4",  pc_plus4,       64'h304);
    checkOutput("hold_ctl",    64'(alu_ctl),   64'h2);

    // Reset between two valid inputs
    applyStimulus(1'b1, 2'b10, 11'b10001011000, 64'd5, 64'd7, 64'h200, 64'h0, 1'b0);
    checkOutput("pre_rst_result", result, 64'd12);
    @(negedge clk);
    operand_a = 64'd40;
    operand_b = 64'd2;
    in_valid  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid",  64'(out_valid), 64'd0);
    checkOutput("mid_rst_result", result,         64'd0);
    checkOutput("mid_rst_zero",   64'(zero),      64'd1);
    checkOutput("mid_rst_plus4",  pc_plus4,       64'd0);
    @(posedge clk);
    #1;
    checkOutput("in_rst_result", result, 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_idle_valid",  64'(out_valid), 64'd0);
    checkOutput("post_rst_idle_result", result,         64'd0);
    applyStimulus(1'b1, 2'b10, 11'b10001011000, 64'd40, 64'd2, 64'h10, 64'h0, 1'b0);
    checkOutput("post_rst_valid",  64'(out_valid), 64'd1);
    checkOutput("post_rst_result", result,         64'd42);
    checkOutput("post_rst_plus4",  pc_plus4,       64'h14);

`ifdef ALU_FLAGS_EN
    // Signed overflow and carry on 0x7FFF.. + 1
    applyStimulus(1'b1, 2'b10, 11'b10001011000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                  64'h0, 64'h0, 1'b0);
    checkOutput("flag_ovf", 64'(overflow), 64'd1);
    checkOutput("flag_neg", 64'(negative), 64'd1);
    checkOutput("flag_cy",  64'(carry),    64'd0);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
